// File: rtl/p405s_dcu_tag_pkg.sv
`default_nettype none
// ============================================================================
// Module  : p405s_dcu_tag_pkg
// Brief   : Shared constants, way-field layout and state encoding for the DCU
//           tag-array controller. Optional parity: P405S_DCU_TAG_PAR_EN.
// Revision: 1.0 - initial release
// ============================================================================
package p405s_dcu_tag_pkg;

    localparam int TAG_W     = 21;
    localparam int IDX_W     = 8;
    localparam int WAY_W     = 24;

    localparam int TAG_LSB   = 0;
    localparam int VALID_BIT = 21;
    localparam int DIRTY_BIT = 22;
    localparam int PAR_BIT   = 23;

    localparam logic [0:IDX_W-1] SWEEP_LAST = 8'd255;

`ifdef P405S_DCU_TAG_PAR_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef enum logic [0:0] {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Builds a valid way field; parity makes the 24 bits XOR to zero.
    function automatic logic [0:WAY_W-1] make_way(input logic [0:TAG_W-1] tag,
                                                  input logic dirty);
        logic [0:WAY_W-1] w;
        w                   = '0;
        w[TAG_LSB +: TAG_W] = tag;
        w[VALID_BIT]        = 1'b1;
        w[DIRTY_BIT]        = dirty;
        w[PAR_BIT]          = PAR_EN & (^{tag, 1'b1, dirty});
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/p405s_dcu_tag_way_cmp.sv
`default_nettype none
// ============================================================================
// Module  : p405s_dcu_tag_way_cmp
// Brief   : Per-way tag compare with optional parity check
//           (P405S_DCU_TAG_PAR_EN).
// Revision: 1.0 - initial release
// ============================================================================
module p405s_dcu_tag_way_cmp
    import p405s_dcu_tag_pkg::*;
(
    input  logic [0:WAY_W-1] i_way,
    input  logic [0:TAG_W-1] i_req_tag,
    output logic             o_hit,
    output logic             o_dirty,
    output logic             o_perr
);

    logic w_valid;
    logic w_tag_eq;
    logic w_par_bad;

    assign w_valid  = i_way[VALID_BIT];
    assign w_tag_eq = (i_way[TAG_LSB +: TAG_W] == i_req_tag);

`ifdef P405S_DCU_TAG_PAR_EN
    // Parity is only meaningful on entries that were filled.
    assign w_par_bad = w_valid & (^i_way);
`else
    logic w_unused_par;
    assign w_unused_par = i_way[PAR_BIT];
    assign w_par_bad    = 1'b0;
`endif

    assign o_hit   = w_valid & w_tag_eq & !w_par_bad;
    assign o_dirty = i_way[DIRTY_BIT];
    assign o_perr  = w_par_bad;

endmodule
`default_nettype wire

// File: rtl/p405s_dcu_tag_ctl.sv
`default_nettype none
// ============================================================================
// Module  : p405s_dcu_tag_ctl
// Brief   : Sole driver of the DCU 256x48 tag array: lookups, fills and the
//           invalidate sweep. Optional parity: P405S_DCU_TAG_PAR_EN.
// Revision: 1.0 - initial release
// ============================================================================
module p405s_dcu_tag_ctl
    import p405s_dcu_tag_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 REQ_VAL,
    output logic                 REQ_RDY,
    input  logic [0:IDX_W-1]     REQ_IDX,
    input  logic [0:TAG_W-1]     REQ_TAG,
    output logic                 RSP_VAL,
    output logic                 RSP_HIT,
    output logic                 RSP_WAY,
    output logic                 RSP_DIRTY,
    output logic                 RSP_MHIT,
    output logic                 RSP_PERR,
    input  logic                 FILL_VAL,
    output logic                 FILL_RDY,
    input  logic [0:IDX_W-1]     FILL_IDX,
    input  logic                 FILL_WAY,
    input  logic [0:TAG_W-1]     FILL_TAG,
    input  logic                 FILL_DIRTY,
    input  logic                 INV_ALL_REQ,
    output logic                 INV_BUSY,
    output logic                 INV_DONE,
    output logic                 TA_CEN,
    output logic [0:2*WAY_W-1]   TA_WEN,
    output logic [0:IDX_W-1]     TA_A,
    output logic [0:2*WAY_W-1]   TA_D,
    input  logic [0:2*WAY_W-1]   TA_Q
);

    state_t             r_state;
    logic [0:IDX_W-1]   r_cnt;
    logic               r_rsp_val;
    logic               r_rsp_hit;
    logic               r_rsp_way;
    logic               r_rsp_dirty;
    logic               r_rsp_mhit;
    logic               r_rsp_perr;

    logic               w_busy;
    logic               w_fill;
    logic               w_lkp;
    logic [0:WAY_W-1]   w_fill_way;
    logic               w_hit0, w_hit1;
    logic               w_dirty0, w_dirty1;
    logic               w_perr0, w_perr1;

    assign w_busy   = RST | (r_state == SWEEP);
    assign INV_BUSY = w_busy;
    assign FILL_RDY = !w_busy & !INV_ALL_REQ;
    assign REQ_RDY  = FILL_RDY & !FILL_VAL;
    assign w_fill   = FILL_VAL & FILL_RDY;
    assign w_lkp    = REQ_VAL & REQ_RDY;
    assign INV_DONE = !RST & (r_state == SWEEP) & (r_cnt == SWEEP_LAST);

    assign w_fill_way = make_way(FILL_TAG, FILL_DIRTY);

    // The array port is idle while reset is held; the sweep starts once it drops.
    always_comb begin
        TA_CEN = 1'b1;
        TA_WEN = '1;
        TA_A   = '0;
        TA_D   = '0;
        if (!RST) begin
            if (r_state == SWEEP) begin
                TA_CEN = 1'b0;
                TA_WEN = '0;
                TA_A   = r_cnt;
            end else if (w_fill) begin
                TA_CEN = 1'b0;
                TA_A   = FILL_IDX;
                if (FILL_WAY) begin
                    TA_WEN[WAY_W:2*WAY_W-1] = '0;
                    TA_D[WAY_W:2*WAY_W-1]   = w_fill_way;
                end else begin
                    TA_WEN[0:WAY_W-1] = '0;
                    TA_D[0:WAY_W-1]   = w_fill_way;
                end
            end else if (w_lkp) begin
                TA_CEN = 1'b0;
                TA_A   = REQ_IDX;
            end
        end
    end

    p405s_dcu_tag_way_cmp u_way0 (
        .i_way     (TA_Q[0:WAY_W-1]),
        .i_req_tag (REQ_TAG),
        .o_hit     (w_hit0),
        .o_dirty   (w_dirty0),
        .o_perr    (w_perr0)
    );

    p405s_dcu_tag_way_cmp u_way1 (
        .i_way     (TA_Q[WAY_W:2*WAY_W-1]),
        .i_req_tag (REQ_TAG),
        .o_hit     (w_hit1),
        .o_dirty   (w_dirty1),
        .o_perr    (w_perr1)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= SWEEP;
            r_cnt       <= '0;
            r_rsp_val   <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_way   <= 1'b0;
            r_rsp_dirty <= 1'b0;
            r_rsp_mhit  <= 1'b0;
            r_rsp_perr  <= 1'b0;
        end else begin
            case (r_state)
                SWEEP: begin
                    r_cnt <= r_cnt + IDX_W'(1);
                    if (r_cnt == SWEEP_LAST)
                        r_state <= IDLE;
                end
                IDLE: begin
                    if (INV_ALL_REQ) begin
                        r_state <= SWEEP;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= SWEEP;
            endcase

            // Way 0 wins on a multi-hit; result fields are zero without a lookup.
            r_rsp_val   <= w_lkp;
            r_rsp_hit   <= w_lkp & (w_hit0 | w_hit1);
            r_rsp_way   <= w_lkp & !w_hit0 & w_hit1;
            r_rsp_dirty <= w_lkp & (w_hit0 ? w_dirty0 : (w_hit1 & w_dirty1));
            r_rsp_mhit  <= w_lkp & w_hit0 & w_hit1;
            r_rsp_perr  <= w_lkp & (w_perr0 | w_perr1);
        end
    end

    assign RSP_VAL   = r_rsp_val;
    assign RSP_HIT   = r_rsp_hit;
    assign RSP_WAY   = r_rsp_way;
    assign RSP_DIRTY = r_rsp_dirty;
    assign RSP_MHIT  = r_rsp_mhit;
    assign RSP_PERR  = r_rsp_perr;

endmodule
`default_nettype wire
